exmem_skid_stage: RTL and testbench

//  Parametrised EX->MEM pipeline stage with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/exmem_skid_stage_if.sv | 34 +++
 rtl/exmem_skid_stage.sv | 100 ++++++++++
 tb/tb_exmem_skid_stage.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/exmem_skid_stage_if.sv
// Valid/ready bus carrying one EX->MEM pipeline entry.
// The master drives the entry and valid; the slave returns ready.
interface exmem_skid_stage_if #(
   parameter int unsigned Xlen   = 32,
   parameter int unsigned RaddrW = 5,
   parameter int unsigned CtrlW  = 4
) ();

   logic              valid;
   logic              ready;
   logic [CtrlW-1:0]  ctrl;
   logic [Xlen-1:0]   alu_res;
   logic [Xlen-1:0]   rs2_data;
   logic [RaddrW-1:0] rd_addr;

   modport master (
      output valid,
      output ctrl,
      output alu_res,
      output rs2_data,
      output rd_addr,
      input  ready
   );

   modport slave (
      input  valid,
      input  ctrl,
      input  alu_res,
      input  rs2_data,
      input  rd_addr,
      output ready
   );

endinterface

// File: rtl/exmem_skid_stage.sv
// EX->MEM pipeline register with a 2-entry skid buffer, registered upstream ready
// and synchronous flush. Entries leave in strict FIFO order from the main register.
module exmem_skid_stage #(
   parameter int unsigned Xlen   = 32,
   parameter int unsigned RaddrW = 5,
   parameter int unsigned CtrlW  = 4,
   parameter bit          KillX0 = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   exmem_skid_stage_if.slave   in_bus,
   exmem_skid_stage_if.master  out_bus,
   output logic [1:0]          occ
);

   typedef struct packed {
      logic [CtrlW-1:0]  ctrl;
      logic [Xlen-1:0]   alu_res;
      logic [Xlen-1:0]   rs2_data;
      logic [RaddrW-1:0] rd_addr;
   } entry_t;

   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   entry_t in_entry;
   logic   main_valid_q, main_valid_d;
   logic   skid_valid_q, skid_valid_d;
   logic   ready_q;
   logic   in_fire;
   logic   out_fire;

   assign in_fire  = in_bus.valid & ready_q;
   assign out_fire = main_valid_q & out_bus.ready;

   // Writes to x0 must never reach the register file.
   always_comb begin
      in_entry.ctrl     = in_bus.ctrl;
      in_entry.alu_res  = in_bus.alu_res;
      in_entry.rs2_data = in_bus.rs2_data;
      in_entry.rd_addr  = in_bus.rd_addr;
      if (KillX0 && (in_bus.rd_addr == {RaddrW{1'b0}})) begin
         in_entry.ctrl[0] = 1'b0;
      end
   end

   always_comb begin
      main_d       = main_q;
      skid_d       = skid_q;
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         if (in_fire) begin
            main_d       = in_entry;
            main_valid_d = 1'b1;
         end
      end else if (!skid_valid_q) begin
         if (in_fire && out_fire) begin
            main_d = in_entry;
         end else if (in_fire) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
         end else if (out_fire) begin
            main_valid_d = 1'b0;
         end
      end else if (out_fire) begin
         main_d       = skid_q;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         main_q       <= main_d;
         skid_q       <= skid_d;
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         // Registered ready: MEM back-pressure never reaches EX combinationally.
         ready_q      <= ~skid_valid_d;
      end
   end

   assign in_bus.ready     = ready_q;
   assign out_bus.valid    = main_valid_q;
   assign out_bus.ctrl     = main_valid_q ? main_q.ctrl : {CtrlW{1'b0}};
   assign out_bus.alu_res  = main_q.alu_res;
   assign out_bus.rs2_data = main_q.rs2_data;
   assign out_bus.rd_addr  = main_q.rd_addr;
   assign occ              = skid_valid_q ? 2'd2 : (main_valid_q ? 2'd1 : 2'd0);

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Directed bench for exmem_skid_stage: reset, streaming, back-pressure, flush,
// x0 squash and mid-operation reset, with hand-computed expectations.
module tb_exmem_skid_stage;

   logic       clk;
   logic       rst;
   logic       flush;
   logic [1:0] occ;
   int         n_vec;
   int         n_err;

   exmem_skid_stage_if #(.Xlen(32), .RaddrW(5), .CtrlW(4)) ex_if ();
   exmem_skid_stage_if #(.Xlen(32), .RaddrW(5), .CtrlW(4)) mem_if ();

   exmem_skid_stage #(
      .Xlen   (32),
      .RaddrW (5),
      .CtrlW  (4),
      .KillX0 (1'b1)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush),
      .in_bus  (ex_if),
      .out_bus (mem_if),
      .occ     (occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r);
      ex_if.valid    = v;
      ex_if.ctrl     = c;
      ex_if.alu_res  = a;
      ex_if.rs2_data = d;
      ex_if.rd_addr  = r;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      flush = 1'b0;
      mem_if.ready = 1'b1;
      drive(1'b1, 4'b1111, 32'h99, 32'h98, 5'd3);
      tick();
      tick();
      check("rst_valid", {31'd0, mem_if.valid}, 32'd0);
      check("rst_ctrl", {28'd0, mem_if.ctrl}, 32'd0);
      check("rst_alu", mem_if.alu_res, 32'd0);
      check("rst_ready", {31'd0, ex_if.ready}, 32'd1);
      check("rst_occ", {30'd0, occ}, 32'd0);
      rst = 1'b0;

      // Streaming at one entry per cycle.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 4'b0001, 32'h100 + i, 32'h200 + i, 5'd1);
         tick();
         check("str_valid", {31'd0, mem_if.valid}, 32'd1);
         check("str_alu", mem_if.alu_res, 32'h100 + i);
         check("str_rs2", mem_if.rs2_data, 32'h200 + i);
         check("str_ready", {31'd0, ex_if.ready}, 32'd1);
         check("str_occ", {30'd0, occ}, 32'd1);
      end
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
      tick();
      check("str_drain_valid", {31'd0, mem_if.valid}, 32'd0);
      check("str_drain_ctrl", {28'd0, mem_if.ctrl}, 32'd0);
      check("str_drain_occ", {30'd0, occ}, 32'd0);

      // Back-pressure: A, B fill the stage, C is blocked.
      mem_if.ready = 1'b0;
      drive(1'b1, 4'b0101, 32'hA, 32'hA0, 5'd2);
      tick();
      check("bp_a_alu", mem_if.alu_res, 32'hA);
      check("bp_a_occ", {30'd0, occ}, 32'd1);
      check("bp_a_ready", {31'd0, ex_if.ready}, 32'd1);
      drive(1'b1, 4'b0001, 32'hB, 32'hB0, 5'd4);
      tick();
      check("bp_b_alu", mem_if.alu_res, 32'hA);
      check("bp_b_occ", {30'd0, occ}, 32'd2);
      check("bp_b_ready", {31'd0, ex_if.ready}, 32'd0);
      drive(1'b1, 4'b1001, 32'hC, 32'hC0, 5'd6);
      tick();
      check("bp_c_alu", mem_if.alu_res, 32'hA);
      check("bp_c_rs2", mem_if.rs2_data, 32'hA0);
      check("bp_c_ctrl", {28'd0, mem_if.ctrl}, 32'h5);
      check("bp_c_occ", {30'd0, occ}, 32'd2);
      check("bp_c_ready", {31'd0, ex_if.ready}, 32'd0);
      mem_if.ready = 1'b1;
      tick();
      check("rel_b_alu", mem_if.alu_res, 32'hB);
      check("rel_b_rd", {27'd0, mem_if.rd_addr}, 32'd4);
      check("rel_b_occ", {30'd0, occ}, 32'd1);
      check("rel_b_ready", {31'd0, ex_if.ready}, 32'd1);
      tick();
      check("rel_c_alu", mem_if.alu_res, 32'hC);
      check("rel_c_ctrl", {28'd0, mem_if.ctrl}, 32'h9);
      check("rel_c_occ", {30'd0, occ}, 32'd1);
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
      tick();
      check("rel_drain_occ", {30'd0, occ}, 32'd0);

      // Flush when full, with D offered.
      mem_if.ready = 1'b0;
      drive(1'b1, 4'b0011, 32'hE1, 32'h0, 5'd7);
      tick();
      drive(1'b1, 4'b0011, 32'hF1, 32'h0, 5'd8);
      tick();
      check("fl_full_occ", {30'd0, occ}, 32'd2);
      drive(1'b1, 4'b0011, 32'hD, 32'h0, 5'd9);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("fl_valid", {31'd0, mem_if.valid}, 32'd0);
      check("fl_ctrl", {28'd0, mem_if.ctrl}, 32'd0);
      check("fl_occ", {30'd0, occ}, 32'd0);
      check("fl_ready", {31'd0, ex_if.ready}, 32'd1);
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
      tick();
      check("fl_no_d", {31'd0, mem_if.valid}, 32'd0);

      // Flush with one entry held and a new entry that would otherwise be accepted.
      drive(1'b1, 4'b0001, 32'h77, 32'h0, 5'd1);
      tick();
      check("fl1_occ_pre", {30'd0, occ}, 32'd1);
      drive(1'b1, 4'b0001, 32'h78, 32'h0, 5'd1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
      check("fl1_occ", {30'd0, occ}, 32'd0);
      check("fl1_valid", {31'd0, mem_if.valid}, 32'd0);
      tick();
      check("fl1_still_empty", {30'd0, occ}, 32'd0);

      // x0 squash of RegWrite.
      mem_if.ready = 1'b1;
      drive(1'b1, 4'b0001, 32'h30, 32'h0, 5'd0);
      tick();
      check("x0_valid", {31'd0, mem_if.valid}, 32'd1);
      check("x0_ctrl", {28'd0, mem_if.ctrl}, 32'h0);
      drive(1'b1, 4'b0001, 32'h31, 32'h0, 5'd5);
      tick();
      check("x5_ctrl", {28'd0, mem_if.ctrl}, 32'h1);
      check("x5_rd", {27'd0, mem_if.rd_addr}, 32'd5);
      drive(1'b1, 4'b1111, 32'h32, 32'h0, 5'd0);
      tick();
      check("x0_other_bits", {28'd0, mem_if.ctrl}, 32'hE);
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
      tick();

      // Mid-operation reset when full.
      mem_if.ready = 1'b0;
      drive(1'b1, 4'b0001, 32'h41, 32'h0, 5'd1);
      tick();
      drive(1'b1, 4'b0001, 32'h42, 32'h0, 5'd1);
      tick();
      check("mr_full_occ", {30'd0, occ}, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_occ", {30'd0, occ}, 32'd0);
      check("mr_valid", {31'd0, mem_if.valid}, 32'd0);
      check("mr_ready", {31'd0, ex_if.ready}, 32'd1);
      check("mr_alu", mem_if.alu_res, 32'd0);
      mem_if.ready = 1'b1;
      drive(1'b1, 4'b0001, 32'h55, 32'h56, 5'd3);
      tick();
      check("mr_next_valid", {31'd0, mem_if.valid}, 32'd1);
      check("mr_next_alu", mem_if.alu_res, 32'h55);
      check("mr_next_rs2", mem_if.rs2_data, 32'h56);
      drive(1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
      tick();
      check("mr_drain_occ", {30'd0, occ}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
